// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings and a
// helper that classifies operations which occupy the unit for several cycles.
package mdu_pkg;

  typedef enum logic [2:0] {
    MduNone  = 3'd0,
    MduMult  = 3'd1,
    MduMultu = 3'd2,
    MduDiv   = 3'd3,
    MduDivu  = 3'd4,
    MduMthi  = 3'd5,
    MduMtlo  = 3'd6,
    MduRsvd  = 3'd7   // behaves as MduNone
  } mdu_op_e;

  // True for operations that compute into the shadow result and set busy.
  function automatic logic is_long_op(mdu_op_e op);
    return (op == MduMult) || (op == MduMultu) || (op == MduDiv) || (op == MduDivu);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic core of the MDU. Produces the full {hi, lo} result
// for MULT/MULTU/DIV/DIVU, including divide-by-zero and signed-overflow cases.
// Ports:
//   op_i  operation code
//   a_i   rs operand (dividend / multiplicand)
//   b_i   rt operand (divisor / multiplier)
//   hi_o  upper product half or remainder
//   lo_o  lower product half or quotient
module mdu_arith
  import mdu_pkg::*;
(
  input  mdu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic               div_zero;
  logic               div_ovf;
  logic        [31:0] div_b;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quot_u;
  logic        [31:0] rem_u;

  assign div_zero = (b_i == 32'd0);
  assign div_ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

  // The divider never sees b==0 or the overflowing pair; those results come
  // from the special cases below, so a safe divisor of 1 is substituted.
  assign div_b = (div_zero || div_ovf) ? 32'd1 : b_i;

  assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};
  assign quot_s = $signed(a_i) / $signed(div_b);
  assign rem_s  = $signed(a_i) % $signed(div_b);
  assign quot_u = a_i / div_b;
  assign rem_u  = a_i % div_b;

  always_comb begin
    hi_o = 32'd0;
    lo_o = 32'd0;
    unique case (op_i)
      MduMult: begin
        hi_o = prod_s[63:32];
        lo_o = prod_s[31:0];
      end
      MduMultu: begin
        hi_o = prod_u[63:32];
        lo_o = prod_u[31:0];
      end
      MduDiv: begin
        if (div_zero) begin
          hi_o = a_i;
          lo_o = 32'hFFFF_FFFF;
        end else if (div_ovf) begin
          hi_o = 32'd0;
          lo_o = 32'h8000_0000;
        end else begin
          hi_o = rem_s;
          lo_o = quot_s;
        end
      end
      MduDivu: begin
        if (div_zero) begin
          hi_o = a_i;
          lo_o = 32'hFFFF_FFFF;
        end else begin
          hi_o = rem_u;
          lo_o = quot_u;
        end
      end
      default: begin
        hi_o = 32'd0;
        lo_o = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// A long operation computes its result into shadow registers on the start
// edge, then holds busy for a fixed number of cycles before committing it.
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset
//   start_i  valid MDU operation in E stage
//   op_i     operation code (mdu_op_e encoding)
//   a_i      rs operand, forwarded
//   b_i      rt operand, forwarded
//   busy_o   long operation in flight
//   hi_o     HI register
//   lo_o     LO register
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MultCycles = 5,
  parameter int unsigned DivCycles  = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned MaxCycles = (MultCycles > DivCycles) ? MultCycles : DivCycles;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       shi_q, shi_d;
  logic [31:0]       slo_q, slo_d;
  mdu_op_e           op;
  logic [31:0]       res_hi;
  logic [31:0]       res_lo;

  assign op = mdu_op_e'(op_i);

  mdu_arith u_arith (
    .op_i (op),
    .a_i  (a_i),
    .b_i  (b_i),
    .hi_o (res_hi),
    .lo_o (res_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    shi_d   = shi_q;
    slo_d   = slo_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (is_long_op(op)) begin
            shi_d   = res_hi;
            slo_d   = res_lo;
            cnt_d   = ((op == MduDiv) || (op == MduDivu)) ? CntW'(DivCycles)
                                                          : CntW'(MultCycles);
            state_d = StBusy;
          end else if (op == MduMthi) begin
            hi_d = a_i;
          end else if (op == MduMtlo) begin
            lo_d = a_i;
          end
        end
      end
      StBusy: begin
        // start_i is ignored here: no restart and no MTHI/MTLO write.
        if (cnt_q == CntW'(1)) begin
          hi_d    = shi_q;
          lo_d    = slo_q;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      shi_q   <= 32'd0;
      slo_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      shi_q   <= shi_d;
      slo_q   <= slo_d;
    end
  end

  assign busy_o = (state_q == StBusy);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu with a result scoreboard.
module tb_mdu;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  localparam logic [2:0] OpNone  = 3'd0;
  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;
  localparam logic [2:0] OpRsvd  = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mdu #(
    .MultCycles (MultN),
    .DivCycles  (DivN)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .op_i    (op),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (busy),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    op    = OpNone;
  endtask

  // Runs a long operation, checks busy length and HI/LO hold, then compares
  // the committed result against the scoreboard. inj != 0 pulses MTHI on
  // that busy cycle.
  task automatic run_long(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int unsigned n, input res_t exp,
                          input int unsigned inj);
    logic [31:0] ph;
    logic [31:0] pl;
    res_t        want;
    int unsigned c;
    ph = hi;
    pl = lo;
    c  = 0;
    sb_q.push_back(exp);
    issue(o, x, y);
    while (busy === 1'b1 && c < 200) begin
      check({tag, "_hold_hi"}, hi, ph);
      check({tag, "_hold_lo"}, lo, pl);
      if (inj != 0 && c + 1 == inj) begin
        start = 1'b1;
        op    = OpMthi;
        a     = 32'h0000_1234;
      end
      tick();
      start = 1'b0;
      op    = OpNone;
      c++;
    end
    check({tag, "_busy_len"}, c, n);
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      want = sb_q.pop_front();
      check({tag, "_hi"}, hi, want.hi);
      check({tag, "_lo"}, lo, want.lo);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = OpNone;
    a     = 32'd0;
    b     = 32'd0;
    #12;
    rst_n = 1'b1;
    tick();
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    // Idle MTHI, then NONE and reserved ops must do nothing.
    issue(OpMthi, 32'hCAFE_0001, 32'd0);
    check("mthi_hi", hi, 32'hCAFE_0001);
    check("mthi_lo", lo, 32'd0);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    issue(OpRsvd, 32'h5555_5555, 32'h1);
    check("rsvd_hi", hi, 32'hCAFE_0001);
    check("rsvd_lo", lo, 32'd0);
    check("rsvd_busy", {31'd0, busy}, 32'd0);
    issue(OpNone, 32'h6666_6666, 32'h2);
    check("none_hi", hi, 32'hCAFE_0001);
    check("none_busy", {31'd0, busy}, 32'd0);

    run_long("mult", OpMult, 32'hFFFF_FFFE, 32'd3, MultN, '{32'hFFFF_FFFF, 32'hFFFF_FFFA}, 0);
    run_long("multu", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MultN,
             '{32'hFFFF_FFFE, 32'h0000_0001}, 0);
    run_long("div_neg", OpDiv, 32'hFFFF_FFF9, 32'd2, DivN, '{32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
    run_long("div_negb", OpDiv, 32'd7, 32'hFFFF_FFFE, DivN, '{32'h0000_0001, 32'hFFFF_FFFD}, 0);
    run_long("divu", OpDivu, 32'd100, 32'd7, DivN, '{32'd2, 32'd14}, 0);
    run_long("divu_z", OpDivu, 32'd7, 32'd0, DivN, '{32'd7, 32'hFFFF_FFFF}, 0);
    run_long("div_z", OpDiv, 32'hFFFF_FFFB, 32'd0, DivN, '{32'hFFFF_FFFB, 32'hFFFF_FFFF}, 0);
    run_long("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, DivN,
             '{32'd0, 32'h8000_0000}, 0);

    // MTHI pulsed on busy cycle 3 must be ignored.
    run_long("div_inj", OpDiv, 32'd100, 32'd7, DivN, '{32'd2, 32'd14}, 3);

    // Reset mid-way through a DIV aborts it without a later commit.
    issue(OpDiv, 32'hFFFF_FFF9, 32'd2);
    repeat (4) tick();
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (15) tick();
    check("abort_late_busy", {31'd0, busy}, 32'd0);
    check("abort_late_hi", hi, 32'd0);
    check("abort_late_lo", lo, 32'd0);

    issue(OpMtlo, 32'h0000_ABCD, 32'd0);
    check("mtlo_lo", lo, 32'h0000_ABCD);
    check("mtlo_hi", hi, 32'd0);
    check("mtlo_busy", {31'd0, busy}, 32'd0);

    check("sb_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
